bs_price_combine: RTL and testbench
===================================

# bs_price_combine

Downstream consumer of the Q16.16 normal-CDF unit in the Black-Scholes datapath. Accepts one option's spot price, discounted strike and the d1/d2 arguments. Drives the CDF unit twice over a start/done handshake, first for N(d1) and then for N(d2). Forms the European call as S·N(d1) − K_disc·N(d2) and the put by put-call parity.

## Interface
Parameters:
- WIDTH, 32: data width; all data ports are signed Q16.16.
- FRAC, 16: fractional bits; products are taken as bits [FRAC+WIDTH-1:FRAC].

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- S  in  WIDTH  spot price.
- K_disc  in  WIDTH  discounted strike K·e^(−rT), computed upstream.
- d1, d2  in  WIDTH  CDF arguments.
- norm_start  out  1  one-cycle request to the CDF unit.
- norm_d  out  WIDTH  CDF argument; held stable from norm_start until the matching norm_done.
- norm_N  in  WIDTH  CDF result; valid while norm_done is high.
- norm_done  in  1  one-cycle completion pulse from the CDF unit.
- call, put  out  WIDTH  prices; hold their value until the next SUB state.
- done  out  1  one-cycle pulse; call and put are valid while it is high.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, REQ1, WAIT1, REQ2, WAIT2, MUL, SUB, DONE.
- IDLE: when start is high, register S, K_disc, d1 and d2, then go to REQ1.
  - Inputs are not re-sampled until the block returns to IDLE.
- REQ1: norm_start = 1 and norm_d = d1 for this cycle. Go to WAIT1.
- WAIT1: wait for norm_done. On norm_done, latch nd1 = norm_N and go to REQ2.
  - The wait has no timeout.
- REQ2 and WAIT2: same as REQ1 and WAIT1, using d2; latch nd2.
- MUL: p1 = (S·nd1)[47:16] and p2 = (K_disc·nd2)[47:16].
  - Each product is a full 64-bit signed multiply.
  - The slice is arithmetic truncation, no rounding and no saturation.
- SUB: form call_raw = p1 − p2 and put_raw = call_raw − S + K_disc, both WIDTH-bit wrapping.
  - call = max(call_raw, 0) and put = max(put_raw, 0).
  - put_raw uses the unclamped call_raw.
- DONE: done = 1 for one cycle, then return to IDLE.
- start while busy is ignored. The request is not queued.
- norm_done outside WAIT1/WAIT2 is ignored. It does not alter nd1 or nd2.
- norm_done in the same cycle as norm_start (REQ state) is ignored. The CDF latency is ≥ 1.
- Inputs are not range-checked. Negative S or K_disc are processed arithmetically as given.

## Timing
- Reset values: state = IDLE; call, put, norm_d and internal registers = 0; done, norm_start and busy = 0.
- Reset asserted mid-operation:
  - Abort at the next edge and return to IDLE with all outputs at reset values.
  - No done pulse is emitted.
  - The CDF unit shares this reset.
- Define cycle 0 as the cycle in which start is sampled in IDLE, and L as the CDF latency (norm_start cycle to norm_done cycle).
  - REQ1 occupies cycle 1; the first norm_done arrives in cycle 1+L.
  - REQ2 occupies cycle 2+L; the second norm_done arrives in cycle 2+2L.
  - MUL occupies cycle 3+2L; SUB occupies cycle 4+2L.
  - done is high in cycle 5+2L. For the standard CDF unit (L = 3) that is cycle 11.
- busy is high from cycle 1 through the DONE cycle inclusive.
- A new start is accepted in the cycle after DONE.
- call and put update at the end of the SUB cycle. They are stable while done is high and until the next SUB.

## Test plan
1. S = K_disc = 0x00640000; CDF model returns 0x8000 for both calls (L = 3) → call = 0, put = 0; done high exactly in cycle 11; busy high in cycles 1–11.
2. S = 0x10000, K_disc = 0x20000, nd1 = 0x2850, nd2 = 0x1000 → call = 0x0850, put = 0x10850; norm_d = d1 during REQ1 and norm_d = d2 during REQ2.
3. S = 0x10000, K_disc = 0x8000, nd1 = 0xD7B0, nd2 = 0xB0F4 → p2 = 0x587A, call = 0x7F36; put_raw = −0xCA, so put clamps to 0.
4. Pulse start in cycles 3 and 7 of an operation, and inject a spurious norm_done in the MUL cycle → exactly one done pulse; results equal the no-glitch run.
5. CDF model with L = 10 → done in cycle 25; norm_d is held constant through each wait.
6. Assert reset in WAIT2 → next cycle all outputs are 0 and state is IDLE; no done pulse. A fresh start then completes with correct values.

Source files
------------

// File: rtl/bs_price_combine.sv
// bs_price_combine
// Final stage of the Black-Scholes datapath. It takes one option's spot price
// S, discounted strike K_disc and the CDF arguments d1/d2. It asks the external
// normal-CDF unit for N(d1) and then N(d2). It then prices the European call
// as S*N(d1) - K_disc*N(d2) and the put by put-call parity. Both prices are
// clamped at zero.
//
// Ports (all data signed Q16.16, WIDTH bits):
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               request pulse, sampled only while idle
//   S, K_disc, d1, d2   operands, captured on an accepted start
//   norm_start/norm_d   request to the CDF unit; norm_d is a register, so it
//                       stays stable from norm_start until the matching done
//   norm_N/norm_done    CDF result, valid while norm_done is high
//   call, put           prices, held until the next SUB cycle
//   done                one-cycle pulse; call/put are valid while it is high
//   busy                high whenever the FSM is not idle
//   state_dbg           current FSM state, for observation only
//
// Handshake: norm_start is a one-cycle request. The CDF unit answers with a
// one-cycle norm_done at least one cycle later. norm_done is honoured only in
// WAIT1/WAIT2 and is ignored in every other state.

module bs_price_combine #(
   parameter int WIDTH = 32,
   parameter int FRAC  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] S,
   input  logic [WIDTH-1:0] K_disc,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   output logic             norm_start,
   output logic [WIDTH-1:0] norm_d,
   input  logic [WIDTH-1:0] norm_N,
   input  logic             norm_done,
   output logic [WIDTH-1:0] call,
   output logic [WIDTH-1:0] put,
   output logic             done,
   output logic             busy,
   output logic [2:0]       state_dbg
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] REQ1  = 3'd1;
   localparam logic [2:0] WAIT1 = 3'd2;
   localparam logic [2:0] REQ2  = 3'd3;
   localparam logic [2:0] WAIT2 = 3'd4;
   localparam logic [2:0] MUL   = 3'd5;
   localparam logic [2:0] SUB   = 3'd6;
   localparam logic [2:0] DONE  = 3'd7;

   logic [2:0]       state_q, state_d;
   logic [WIDTH-1:0] s_q, s_d, k_q, k_d, d2_q, d2_d;
   logic [WIDTH-1:0] nd1_q, nd1_d, nd2_q, nd2_d;
   logic [WIDTH-1:0] p1_q, p1_d, p2_q, p2_d;
   logic [WIDTH-1:0] call_q, call_d, put_q, put_d;
   logic [WIDTH-1:0] norm_d_q, norm_d_d;

   logic signed [2*WIDTH-1:0] prod1, prod2;
   logic [WIDTH-1:0]          call_raw, put_raw;

   // Full-width signed products. The Q16.16 result is the slice above the
   // fractional bits. This is plain truncation toward -inf.
   assign prod1 = $signed(s_q) * $signed(nd1_q);
   assign prod2 = $signed(k_q) * $signed(nd2_q);

   // put_raw is built from the unclamped call value (parity).
   assign call_raw = p1_q - p2_q;
   assign put_raw  = call_raw - s_q + k_q;

   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      k_d      = k_q;
      d2_d     = d2_q;
      nd1_d    = nd1_q;
      nd2_d    = nd2_q;
      p1_d     = p1_q;
      p2_d     = p2_q;
      call_d   = call_q;
      put_d    = put_q;
      norm_d_d = norm_d_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               s_d      = S;
               k_d      = K_disc;
               d2_d     = d2;
               // d1 goes straight into the argument register used by REQ1.
               norm_d_d = d1;
               state_d  = REQ1;
            end
         end
         REQ1:  state_d = WAIT1;
         WAIT1: begin
            if (norm_done) begin
               nd1_d    = norm_N;
               norm_d_d = d2_q;
               state_d  = REQ2;
            end
         end
         REQ2:  state_d = WAIT2;
         WAIT2: begin
            if (norm_done) begin
               nd2_d   = norm_N;
               state_d = MUL;
            end
         end
         MUL: begin
            p1_d    = prod1[FRAC+WIDTH-1:FRAC];
            p2_d    = prod2[FRAC+WIDTH-1:FRAC];
            state_d = SUB;
         end
         SUB: begin
            call_d  = call_raw[WIDTH-1] ? '0 : call_raw;
            put_d   = put_raw[WIDTH-1]  ? '0 : put_raw;
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         s_q      <= '0;
         k_q      <= '0;
         d2_q     <= '0;
         nd1_q    <= '0;
         nd2_q    <= '0;
         p1_q     <= '0;
         p2_q     <= '0;
         call_q   <= '0;
         put_q    <= '0;
         norm_d_q <= '0;
      end else begin
         state_q  <= state_d;
         s_q      <= s_d;
         k_q      <= k_d;
         d2_q     <= d2_d;
         nd1_q    <= nd1_d;
         nd2_q    <= nd2_d;
         p1_q     <= p1_d;
         p2_q     <= p2_d;
         call_q   <= call_d;
         put_q    <= put_d;
         norm_d_q <= norm_d_d;
      end
   end

   assign norm_start = (state_q == REQ1) || (state_q == REQ2);
   assign norm_d     = norm_d_q;
   assign call       = call_q;
   assign put        = put_q;
   assign done       = (state_q == DONE);
   assign busy       = (state_q != IDLE);
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_bs_price_combine.sv
// Bench for bs_price_combine. Includes a behavioural CDF unit with
// programmable latency. Expected prices are hand-computed and queued per
// operation, and a monitor compares them whenever done is high.

module tb_bs_price_combine;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] S, K_disc, d1, d2;
   logic        norm_start;
   logic [31:0] norm_d;
   logic [31:0] norm_N;
   logic        norm_done;
   logic [31:0] call, put;
   logic        done, busy;
   logic [2:0]  state_dbg;

   int checks   = 0;
   int failures = 0;

   logic [63:0] exp_q[$];

   // CDF model controls
   int          m_lat = 3;
   logic [31:0] m_d1, m_nd1, m_nd2;
   logic        m_done = 1'b0;
   logic [31:0] m_N = '0;
   logic        spur = 1'b0;

   assign norm_done = m_done | spur;
   assign norm_N    = m_N;

   bs_price_combine #(.WIDTH(32), .FRAC(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .S          (S),
      .K_disc     (K_disc),
      .d1         (d1),
      .d2         (d2),
      .norm_start (norm_start),
      .norm_d     (norm_d),
      .norm_N     (norm_N),
      .norm_done  (norm_done),
      .call       (call),
      .put        (put),
      .done       (done),
      .busy       (busy),
      .state_dbg  (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Behavioural CDF unit: it sees norm_start at a negedge and answers
   // m_lat cycles later with a one-cycle norm_done. It also checks that
   // norm_d holds steady during the wait.
   initial begin : cdf_model
      logic [31:0] arg;
      forever begin
         @(negedge clk);
         if (norm_start && !reset) begin
            arg = norm_d;
            for (int i = 0; i < m_lat; i++) begin
               @(posedge clk);
               if (i < m_lat - 1) begin
                  @(negedge clk);
                  if (busy) check("norm_d_hold", {32'h0, norm_d}, {32'h0, arg});
               end
            end
            #1;
            m_done = 1'b1;
            m_N    = (arg == m_d1) ? m_nd1 : m_nd2;
            @(posedge clk);
            #1;
            m_done = 1'b0;
            m_N    = '0;
         end
      end
   end

   // Scoreboard monitor
   initial begin : monitor
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (done) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done at %0t: got done=1 expected no pulse", $time);
            end else begin
               e = exp_q.pop_front();
               check("call", {32'h0, call}, {32'h0, e[63:32]});
               check("put",  {32'h0, put},  {32'h0, e[31:0]});
            end
         end
      end
   end

   // Caller is positioned #1 after a rising edge. This cycle is cycle 0.
   task automatic run_op(input logic [31:0] s_v, input logic [31:0] k_v,
                         input logic [31:0] d1_v, input logic [31:0] d2_v,
                         input logic [31:0] nd1_v, input logic [31:0] nd2_v,
                         input int lat, input logic [31:0] ec, input logic [31:0] ep,
                         input bit glitch);
      int last;
      last  = 5 + 2 * lat;
      m_lat = lat;
      m_d1  = d1_v;
      m_nd1 = nd1_v;
      m_nd2 = nd2_v;
      exp_q.push_back({ec, ep});
      start = 1'b1; S = s_v; K_disc = k_v; d1 = d1_v; d2 = d2_v;
      @(posedge clk); #1;
      // Scramble the inputs so any late re-sampling shows up.
      start = 1'b0; S = 32'hDEAD_BEEF; K_disc = 32'h1234_5678; d1 = 32'h0BAD_0001; d2 = 32'h0BAD_0002;
      for (int cyc = 1; cyc <= last + 1; cyc++) begin
         if (glitch) begin
            start = (cyc == 3 || cyc == 7);
            spur  = (cyc == 3 + 2 * lat);
         end
         @(negedge clk);
         check("busy", {63'h0, busy}, {63'h0, (cyc <= last)});
         check("norm_start", {63'h0, norm_start}, {63'h0, (cyc == 1 || cyc == 2 + lat)});
         if (cyc == 1)       check("norm_d_req1", {32'h0, norm_d}, {32'h0, d1_v});
         if (cyc == 2 + lat) check("norm_d_req2", {32'h0, norm_d}, {32'h0, d2_v});
         check("done_timing", {63'h0, done}, {63'h0, (cyc == last)});
         if (cyc == last + 1) begin
            check("call_hold", {32'h0, call}, {32'h0, ec});
            check("put_hold",  {32'h0, put},  {32'h0, ep});
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      spur  = 1'b0;
      check("sb_drained", 64'(exp_q.size()), 64'h0);
   endtask

   initial begin : stimulus
      reset = 1'b1; start = 1'b0;
      S = '0; K_disc = '0; d1 = '0; d2 = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_call",  {32'h0, call},   64'h0);
      check("rst_put",   {32'h0, put},    64'h0);
      check("rst_norm_d",{32'h0, norm_d}, 64'h0);
      check("rst_flags", {61'h0, done, norm_start, busy}, 64'h0);
      check("rst_state", {61'h0, state_dbg}, 64'h0);
      @(posedge clk); #1;

      // 1: at the money, N = 0.5 both times
      run_op(32'h0064_0000, 32'h0064_0000, 32'h0000_1000, 32'h0000_2000,
             32'h0000_8000, 32'h0000_8000, 3, 32'h0, 32'h0, 1'b0);
      // 2: small prices
      run_op(32'h0001_0000, 32'h0002_0000, 32'h0000_3000, 32'hFFFF_C000,
             32'h0000_2850, 32'h0000_1000, 3, 32'h0000_0850, 32'h0001_0850, 1'b0);
      // 3: put clamps to zero
      run_op(32'h0001_0000, 32'h0000_8000, 32'h0001_0000, 32'h0000_8000,
             32'h0000_D7B0, 32'h0000_B0F4, 3, 32'h0000_7F36, 32'h0, 1'b0);
      // 4: run 2 again with ignored start pulses and a stray norm_done in MUL
      run_op(32'h0001_0000, 32'h0002_0000, 32'h0000_3000, 32'hFFFF_C000,
             32'h0000_2850, 32'h0000_1000, 3, 32'h0000_0850, 32'h0001_0850, 1'b1);
      // 5: long CDF latency, done in cycle 25
      run_op(32'h0001_0000, 32'h0000_8000, 32'h0001_0000, 32'h0000_8000,
             32'h0000_D7B0, 32'h0000_B0F4, 10, 32'h0000_7F36, 32'h0, 1'b0);
      // Truncation: 1.5 * 0x5555 = 0x7FFF8000 -> 0x7FFF; put_raw = -2
      run_op(32'h0001_8000, 32'h0001_0000, 32'h0000_0100, 32'h0000_0200,
             32'h0000_5555, 32'h0000_0001, 1, 32'h0000_7FFE, 32'h0, 1'b0);
      // Negative spot: call_raw = -1.0 clamps to 0; put_raw = +1.0
      run_op(32'hFFFF_0000, 32'h0001_0000, 32'h0000_0100, 32'h0000_0200,
             32'h0000_8000, 32'h0000_8000, 2, 32'h0, 32'h0001_0000, 1'b0);

      // 6: reset during WAIT2 (cycles 6..8 for L = 3)
      m_lat = 3; m_d1 = 32'h0000_3000; m_nd1 = 32'h0000_2850; m_nd2 = 32'h0000_1000;
      start = 1'b1; S = 32'h0001_0000; K_disc = 32'h0002_0000; d1 = 32'h0000_3000; d2 = 32'hFFFF_C000;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 1; cyc < 7; cyc++) begin
         @(posedge clk); #1;
      end
      check("pre_rst_state", {61'h0, state_dbg}, 64'd4);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("abort_state",  {61'h0, state_dbg}, 64'h0);
      check("abort_flags",  {61'h0, done, norm_start, busy}, 64'h0);
      check("abort_call",   {32'h0, call}, 64'h0);
      check("abort_put",    {32'h0, put}, 64'h0);
      check("abort_norm_d", {32'h0, norm_d}, 64'h0);
      // Let the CDF model's stale answer drain; any done pulse here fails.
      repeat (12) @(posedge clk);
      #1;
      run_op(32'h0001_0000, 32'h0002_0000, 32'h0000_3000, 32'hFFFF_C000,
             32'h0000_2850, 32'h0000_1000, 3, 32'h0000_0850, 32'h0001_0850, 1'b0);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
